// File: rtl/count_led_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | count_led_display                                                          |
// | Stability-filtered LED display of the upstream {upper, lower} count, with  |
// | decouple/recovery handling and a saturating accept counter.                |
// | Optional feature macro: LED_BLINK_EN (blink LEDs while decoupled).         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module count_led_display #(
  parameter int STABLE_CYCLES  = 4,
  parameter int RECOVER_CYCLES = 16,
  parameter int BLINK_CYCLES   = 8
) (
  input  logic       gclk,
  input  logic       rst_n,
  input  logic [3:0] upper,
  input  logic [3:0] lower,
  input  logic       decouple,
  output logic [7:0] led,
  output logic       accept,
  output logic       decoupled,
  output logic [7:0] accept_cnt
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int RW = $clog2(RECOVER_CYCLES + 1);

  localparam logic [1:0] c_run       = 2'd0;
  localparam logic [1:0] c_decoupled = 2'd1;
  localparam logic [1:0] c_recover   = 2'd2;

  localparam logic [SW-1:0] c_stab_max = SW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] c_rec_load = RW'(RECOVER_CYCLES - 1);

  if (STABLE_CYCLES < 1) begin : g_chk_stable
    $error("STABLE_CYCLES must be at least 1");
  end
  if (RECOVER_CYCLES < 1) begin : g_chk_recover
    $error("RECOVER_CYCLES must be at least 1");
  end
  if (BLINK_CYCLES < 1) begin : g_chk_blink
    $error("BLINK_CYCLES must be at least 1");
  end

  logic [7:0]    r_in_q;
  logic [7:0]    r_cand;
  logic [7:0]    r_held;
  logic [SW-1:0] r_stab;
  logic [RW-1:0] r_rcnt;
  logic [1:0]    r_state;
  logic          r_first;
  logic          r_accept;
  logic [7:0]    r_cnt;
  logic          w_accept_cond;

  // The first RUN cycle after recovery only reloads the candidate, so it never accepts.
  assign w_accept_cond = (r_state == c_run) && !decouple && !r_first &&
                         (r_in_q == r_cand) && (r_stab == c_stab_max) &&
                         (r_cand != r_held);

  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_q   <= 8'h00;
      r_cand   <= 8'h00;
      r_held   <= 8'h00;
      r_stab   <= '0;
      r_rcnt   <= '0;
      r_state  <= c_run;
      r_first  <= 1'b0;
      r_accept <= 1'b0;
      r_cnt    <= 8'h00;
    end else begin
      r_in_q   <= {upper, lower};
      r_accept <= w_accept_cond;
      if (w_accept_cond) begin
        r_held <= r_cand;
        if (r_cnt != 8'hFF) begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
      case (r_state)
        c_run: begin
          if (decouple) begin
            r_state <= c_decoupled;
            r_stab  <= '0;
          end else if (r_first) begin
            r_first <= 1'b0;
            r_cand  <= r_in_q;
            r_stab  <= '0;
          end else if (r_in_q != r_cand) begin
            r_cand <= r_in_q;
            r_stab <= '0;
          end else if (r_stab != c_stab_max) begin
            r_stab <= r_stab + 1'b1;
          end
        end
        c_decoupled: begin
          r_stab <= '0;
          if (!decouple) begin
            r_state <= c_recover;
            r_rcnt  <= c_rec_load;
          end
        end
        c_recover: begin
          if (decouple) begin
            r_state <= c_decoupled;
            r_rcnt  <= '0;
          end else if (r_rcnt == '0) begin
            r_state <= c_run;
            r_first <= 1'b1;
          end else begin
            r_rcnt <= r_rcnt - 1'b1;
          end
        end
        default: r_state <= c_run;
      endcase
    end
  end

  assign accept     = r_accept;
  assign accept_cnt = r_cnt;
  assign decoupled  = (r_state != c_run);

`ifdef LED_BLINK_EN
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam logic [BW-1:0] c_blink_max = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] r_bcnt;
  logic          r_phase;

  // Phase 0 shows blank; the counter restarts whenever the block is in RUN.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (r_state == c_run) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (r_bcnt == c_blink_max) begin
      r_bcnt  <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_bcnt <= r_bcnt + 1'b1;
    end
  end

  assign led = ((r_state != c_run) && !r_phase) ? 8'h00 : r_held;
`else
  assign led = r_held;
`endif

endmodule
`default_nettype wire

// File: tb/tb_count_led_display.sv
`default_nettype none
// Self-checking bench for count_led_display: table segments, hand sequences
// and random traffic, all checked against a windowed behavioural model.
module tb_count_led_display;
  localparam int STABLE  = 4;
  localparam int RECOVER = 16;
  localparam int BLINK   = 8;
  localparam int HMAX    = 8192;

  logic       gclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] upper = 4'h0;
  logic [3:0] lower = 4'h0;
  logic       decouple = 1'b0;
  logic [7:0] led;
  logic       accept;
  logic       decoupled;
  logic [7:0] accept_cnt;

  count_led_display #(
    .STABLE_CYCLES (STABLE),
    .RECOVER_CYCLES(RECOVER),
    .BLINK_CYCLES  (BLINK)
  ) dut (
    .gclk      (gclk),
    .rst_n     (rst_n),
    .upper     (upper),
    .lower     (lower),
    .decouple  (decouple),
    .led       (led),
    .accept    (accept),
    .decoupled (decoupled),
    .accept_cnt(accept_cnt)
  );

  always #5 gclk = ~gclk;

  int checks = 0;
  int errors = 0;

  // Model history, indexed by edge number since reset release.
  logic [7:0] s_h   [HMAX];  // value sampled at each edge
  bit         run_h [HMAX];  // edge was a filtering edge (RUN, no decouple)
  bit         dec_h [HMAX];  // decoupled level after each edge
  int         t;
  int         last_dec;
  int         entry;
  logic [7:0] m_held;
  logic [7:0] m_cnt;
  bit         m_acc;

  typedef struct {
    logic [7:0] val;
    logic       dec;
    int         cycles;
    logic [7:0] exp_led;
    logic [7:0] exp_cnt;
  } seg_t;
  seg_t tbl[6];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h (edge %0d)", name, act, exp, t);
    end
  endtask

  task automatic model_reset();
    t        = 0;
    s_h[0]   = 8'h00;
    run_h[0] = 1'b1;
    dec_h[0] = 1'b0;
    last_dec = -1;
    entry    = 0;
    m_held   = 8'h00;
    m_cnt    = 8'h00;
    m_acc    = 1'b0;
  endtask

  // Accept iff the last STABLE+1 samples agree, differ from the shown value,
  // and the whole filtering window consisted of undisturbed RUN edges.
  function automatic bit win_accept();
    if (t - STABLE < 1) return 1'b0;
    for (int e = t - STABLE; e <= t; e++)
      if (!run_h[e]) return 1'b0;
    for (int e = t - STABLE - 1; e < t; e++)
      if (s_h[e] != s_h[t-1]) return 1'b0;
    return s_h[t-1] != m_held;
  endfunction

  task automatic step(input logic [7:0] v, input logic d);
    logic [7:0] exp_led;
    upper    = v[7:4];
    lower    = v[3:0];
    decouple = d;
    @(posedge gclk);
    if (t >= HMAX - 2) begin
      $display("FAIL history: edge budget %0d exhausted", HMAX);
      $fatal(1, "bench history overflow");
    end
    t++;
    s_h[t] = v;
    if (d) last_dec = t;
    if (d && !dec_h[t-1]) entry = t;
    run_h[t] = !dec_h[t-1] && !d;
    dec_h[t] = (last_dec >= 0) && (t - last_dec <= RECOVER);
    m_acc = win_accept();
    if (m_acc) begin
      m_held = s_h[t-1];
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
    exp_led = m_held;
`ifdef LED_BLINK_EN
    if (dec_h[t] && (((t - entry) / BLINK) % 2 == 0)) exp_led = 8'h00;
`endif
    #1;
    chk("led", led, exp_led);
    chk("accept", {7'b0, accept}, {7'b0, m_acc});
    chk("decoupled", {7'b0, decoupled}, {7'b0, dec_h[t]});
    chk("accept_cnt", accept_cnt, m_cnt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge gclk);
    #1;
    chk("rst_led", led, 8'h00);
    chk("rst_accept", {7'b0, accept}, 8'h00);
    chk("rst_decoupled", {7'b0, decoupled}, 8'h00);
    chk("rst_cnt", accept_cnt, 8'h00);
    @(negedge gclk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int acc_idx;
    int pulses;
    int cyc;
    logic [7:0] v;
    logic [7:0] cnt_before;

    model_reset();
    do_reset();

    // Reset/steady, single accept with exact latency, glitch filter.
    tbl[0] = '{8'h00, 1'b0, 20, 8'h00, 8'h00};
    tbl[1] = '{8'h3A, 1'b0, 5,  8'h00, 8'h00};
    tbl[2] = '{8'h3A, 1'b0, 1,  8'h3A, 8'h01};
    tbl[3] = '{8'h11, 1'b0, 3,  8'h3A, 8'h01};
    tbl[4] = '{8'h22, 1'b0, 5,  8'h3A, 8'h01};
    tbl[5] = '{8'h22, 1'b0, 1,  8'h22, 8'h02};
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < tbl[i].cycles; c++) step(tbl[i].val, tbl[i].dec);
      chk($sformatf("tbl%0d_led", i), led, tbl[i].exp_led);
      chk($sformatf("tbl%0d_cnt", i), accept_cnt, tbl[i].exp_cnt);
    end

    // Decouple window with random inputs, then 0x55 steady.
    for (int i = 0; i < 10; i++) step(8'($urandom), 1'b1);
    acc_idx = 0;
    for (int i = 1; i <= 30; i++) begin
      step(8'h55, 1'b0);
      if (accept && acc_idx == 0) acc_idx = i;
      if (i == 16) chk("dec_hold_16", {7'b0, decoupled}, 8'h01);
      if (i == 17) chk("dec_low_17", {7'b0, decoupled}, 8'h00);
      if (i == 21) chk("dec_led_21", led, 8'h22);
    end
    chk("dec_accept_latency", 8'(acc_idx), 8'd22);
    chk("dec_led_final", led, 8'h55);

    // Decouple rises on the exact accept edge.
    cnt_before = accept_cnt;
    for (int i = 0; i < 5; i++) step(8'h66, 1'b0);
    step(8'h66, 1'b1);
    chk("coll_accept", {7'b0, accept}, 8'h00);
    chk("coll_cnt", accept_cnt, cnt_before);
    chk("coll_led", led, 8'h55);
    for (int i = 0; i < 25; i++) step(8'h55, 1'b0);
    chk("coll_after_led", led, 8'h55);

    // Random traffic with occasional decouple bursts.
    cyc = 0;
    v = 8'h55;
    while (cyc < 800) begin
      if ($urandom_range(0, 9) == 0) begin
        int n = $urandom_range(1, 12);
        for (int i = 0; i < n; i++) step(8'($urandom), 1'b1);
        cyc += n;
      end else begin
        int n = $urandom_range(1, 8);
        if ($urandom_range(0, 3) != 0) v = 8'($urandom_range(0, 7)) << 4;
        for (int i = 0; i < n; i++) step(v, 1'b0);
        cyc += n;
      end
    end
    for (int i = 0; i < 25; i++) step(8'h01, 1'b0);

    // Saturation: alternate 0x02/0x01 for 260 accepts.
    pulses = 0;
    for (int a = 0; a < 260; a++) begin
      v = (a % 2 == 0) ? 8'h02 : 8'h01;
      for (int i = 0; i < 6; i++) begin
        step(v, 1'b0);
        if (accept) pulses++;
      end
    end
    chk("sat_pulses", 8'(pulses), 8'(260));
    chk("sat_cnt", accept_cnt, 8'hFF);

`ifdef LED_BLINK_EN
    for (int i = 0; i < 20; i++) step(8'h33, 1'b1);
    for (int i = 0; i < 20; i++) step(8'h01, 1'b0);
`endif

    // Reset in the middle of RECOVER.
    for (int i = 0; i < 3; i++) step(8'h01, 1'b1);
    for (int i = 0; i < 5; i++) step(8'h01, 1'b0);
    chk("pre_rst_decoupled", {7'b0, decoupled}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_led", led, 8'h00);
    chk("midrst_accept", {7'b0, accept}, 8'h00);
    chk("midrst_decoupled", {7'b0, decoupled}, 8'h00);
    chk("midrst_cnt", accept_cnt, 8'h00);
    do_reset();
    for (int i = 0; i < 6; i++) step(8'h77, 1'b0);
    chk("post_rst_led", led, 8'h77);
    chk("post_rst_cnt", accept_cnt, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/count_led_display.md
# count_led_display

Downstream consumer of the reconfigurable counter stage's registered `upper`/`lower` nibbles. It qualifies the 8-bit value `{upper, lower}` with a stability filter and drives a held LED bus. It ignores its inputs while the upstream partition is decoupled for reconfiguration, then waits a recovery window before it trusts them again. It emits an accept pulse and a saturating count of accepted updates.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical samples required before a value is accepted. Minimum 1.
- `RECOVER_CYCLES`, 16: cycles to wait after `decouple` falls before filtering resumes. Minimum 1.
- `BLINK_CYCLES`, 8: LED toggle half-period while decoupled. Used only with `LED_BLINK_EN`.
- `gclk` in 1: the block's single clock; all logic is clocked on its rising edge.
- `rst_n` in 1: reset, asynchronous assertion, active-low. All state clears immediately.
- `upper` in 4: upstream upper count nibble.
- `lower` in 4: upstream lower count nibble.
- `decouple` in 1: high while the upstream partition is being reconfigured; its outputs are invalid.
- `led` out 8: last accepted value, MSB = `upper[3]` (or the blink pattern).
- `accept` out 1: one-cycle pulse when `led` takes a new accepted value.
- `decoupled` out 1: high in states DECOUPLED and RECOVER.
- `accept_cnt` out 8: number of accepted updates since reset, saturating at 255.

## Operation
- Sample register: `in_q <= {upper, lower}` every edge, unconditionally.
- State machine:
  - **RUN**
    - Candidate register `cand` and stability counter `stab` (width `$clog2(STABLE_CYCLES+1)`).
    - If `in_q != cand`: `cand <= in_q`, `stab <= 0`.
    - Otherwise `stab` increments, saturating at `STABLE_CYCLES-1`.
    - Accept when `stab == STABLE_CYCLES-1`, `in_q == cand` and `cand != held`: `held <= cand`, assert `accept` for one cycle, increment `accept_cnt`.
    - A value equal to `held` never re-accepts.
  - **DECOUPLED**
    - Entered from any state when `decouple == 1`.
    - `held` is frozen; `stab` is cleared; no accept.
  - **RECOVER**
    - Entered when `decouple` falls; the recovery counter loads `RECOVER_CYCLES-1` and counts down.
    - Goes to RUN after the terminal count.
    - On entering RUN, `cand <= in_q` and `stab <= 0`.
    - `decouple` rising again returns to DECOUPLED and discards the remaining count.
- Output: `led = held`, except in the blink mode described under Configuration.
- Simultaneous events:
  - `decouple` rising in the same cycle as an accept condition: decouple wins. No accept, `held` unchanged, `accept_cnt` unchanged.
  - Input change in the same cycle the stability counter saturates: the change wins; the counter restarts.
- `accept_cnt` stays at 255 once reached; `accept` still pulses.

## Timing
- Reset values:
  - `led = 0x00`, `accept = 0`, `decoupled = 0`, `accept_cnt = 0`.
  - `held = cand = in_q = 0x00`; state RUN; all counters 0.
  - A reset value of 0x00 is therefore never accepted until another value has been seen.
- Acceptance latency: a new value is stable on the inputs before edge k and held steady. `led` and `accept` change after edge k+`STABLE_CYCLES`+1.
  - STABLE_CYCLES=4: edge k+5.
- `accept` is registered and is high for exactly one cycle, coincident with the first cycle of the new `led` value.
- `decoupled` is registered.
  - Goes high the cycle after `decouple` is sampled high.
  - Goes low the cycle after the RECOVER terminal count.
  - Total low-going latency from `decouple` falling: `RECOVER_CYCLES`+1 edges.
- Earliest accept after `decouple` falls: `RECOVER_CYCLES`+`STABLE_CYCLES`+2 edges.
- `rst_n` deasserting has no synchronizer in this block; the deassertion is synchronised upstream. Mid-operation reset aborts any state, including DECOUPLED and RECOVER.

## Configuration
- `LED_BLINK_EN` defined:
  - In DECOUPLED and RECOVER, `led` alternates between `held` and `0x00`, starting with `0x00` on entry.
  - The phase toggles every `BLINK_CYCLES` cycles; the blink counter is cleared on entry.
  - `led` returns to `held` on the first RUN cycle.
- `LED_BLINK_EN` undefined:
  - `led = held` in all states.
  - No blink counter is built, and the `BLINK_CYCLES` parameter is unused.

## Test plan
- **Reset and steady input:** hold `rst_n=0`, then release with inputs at 0x00 for 20 cycles -> `led=0x00`, `accept` never high, `accept_cnt=0`.
- **Single accept:** STABLE_CYCLES=4; drive 0x3A steady before edge k -> `led=0x3A` and `accept=1` after edge k+5 only; `accept_cnt=1`.
- **Glitch filter:** drive 0x11 for 3 cycles, then 0x22 steady -> 0x11 never appears on `led`; 0x22 is accepted 5 edges after it first appears.
- **Decouple window:** with `held=0x22`, pulse `decouple` for 10 cycles while inputs toggle randomly, then drive 0x55 steady.
  - `decoupled` spans the window plus the 16 recovery cycles.
  - `led` stays 0x22 throughout; 0x55 is accepted 22 edges after `decouple` falls.
- **Decouple versus accept collision:** raise `decouple` on the exact accept cycle -> no `accept` pulse; `accept_cnt` and `led` unchanged.
- **Saturation, blink and mid-operation reset:** alternate 0x01/0x02 for 256 accepts -> `accept_cnt` stays 255 while `accept` keeps pulsing.
  - With `LED_BLINK_EN`, `decouple=1` -> `led` alternates 0x00/`held` every 8 cycles.
  - Drop `rst_n` mid-RECOVER -> all outputs read 0 immediately.
